alu_seq: RTL and testbench

Parametrised, handshaked ALU for the core's execute stage, and the XLEN-generic successor to the fixed 64-bit combinational ALU. It keeps the existing 4-bit op encodings and the zero flag, and adds set-less-than, shifts, and iterative unsigned multiply/divide/remainder. Operands enter through a valid/ready handshake and results leave through one. Multi-cycle ops stall the issuing stage through in_ready.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 91 +++++++++
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation encodings, controller
// states and the helper that tells single-cycle ops from iterative ones.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_MUL  = 4'b0011,
    OP_DIVU = 4'b0100,
    OP_REMU = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_NOR  = 4'b1100
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True for ops that go through the iterative multiply/divide datapath
  // (a zero divisor is still short-circuited by the controller).
  function automatic logic is_multicycle(aluop_e op);
    case (op)
      OP_MUL, OP_DIVU, OP_REMU: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (radix-2 shift-add) and restoring divide.
// One bit is processed per cycle for XLEN cycles after start.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        load operands and begin iterating (div selects divide)
//   div          1 = divide a/b, 0 = multiply a*b
//   a, b         operands (sampled only on start)
//   done         high during the final iteration; outputs below are then final
//   prod         low XLEN bits of the product after this cycle's step
//   quot, rem    quotient and remainder after this cycle's step
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] prod,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int SHW = $clog2(XLEN);

  // acc_r: product accumulator or partial remainder
  // opa_r: shifting multiplicand or fixed divisor
  // opb_r: shifting multiplier or dividend/quotient shift register
  logic [SHW:0]    cnt_r;
  logic            div_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] opa_r;
  logic [XLEN-1:0] opb_r;

  logic [XLEN:0]   shifted_s;
  logic            ge_s;
  logic [XLEN-1:0] prod_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] quot_s;

  // One step of each algorithm, computed from the current registers
  always_comb begin
    prod_s    = acc_r + (opb_r[0] ? opa_r : {XLEN{1'b0}});
    // Remainder can reach 2*divisor-1 after the shift, so compare in XLEN+1 bits.
    shifted_s = {acc_r, opb_r[XLEN-1]};
    ge_s      = (shifted_s >= {1'b0, opa_r});
    if (ge_s) begin
      rem_s = XLEN'(shifted_s - {1'b0, opa_r});
    end else begin
      rem_s = shifted_s[XLEN-1:0];
    end
    quot_s = {opb_r[XLEN-2:0], ge_s};
  end

  assign done = (cnt_r == {{SHW{1'b0}}, 1'b1});
  assign prod = prod_s;
  assign quot = quot_s;
  assign rem  = rem_s;

  // Operand load on start, then one iteration per cycle while the counter runs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {(SHW+1){1'b0}};
      div_r <= 1'b0;
      acc_r <= {XLEN{1'b0}};
      opa_r <= {XLEN{1'b0}};
      opb_r <= {XLEN{1'b0}};
    end else if (start) begin
      cnt_r <= (SHW+1)'(XLEN);
      div_r <= div;
      acc_r <= {XLEN{1'b0}};
      opa_r <= div ? b : a;
      opb_r <= div ? a : b;
    end else if (cnt_r != {(SHW+1){1'b0}}) begin
      cnt_r <= cnt_r - {{SHW{1'b0}}, 1'b1};
      if (div_r) begin
        acc_r <= rem_s;
        opb_r <= quot_s;
      end else begin
        acc_r <= prod_s;
        opa_r <= {opa_r[XLEN-2:0], 1'b0};
        opb_r <= {1'b0, opb_r[XLEN-1:1]};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU. Single-cycle ops resolve at accept; MUL and
// non-zero DIVU/REMU iterate in muldiv_iter for XLEN cycles. One op in flight.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (accept = in_valid & in_ready)
//   a, b, aluop           operands and 4-bit op select
//   out_valid/out_ready   result handshake
//   result, zero          registered result and its zero flag
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      aluop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_r;
  state_e          state_nx_s;
  logic [XLEN-1:0] result_r;
  logic            zero_r;
  logic            rem_sel_r;

  aluop_e          op_s;
  logic [SHW-1:0]  shamt_s;
  logic            b_zero_s;
  logic            accept_s;
  logic            mul_start_s;
  logic            div_start_s;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] md_res_s;
  logic            md_done_s;
  logic [XLEN-1:0] md_prod_s;
  logic [XLEN-1:0] md_quot_s;
  logic [XLEN-1:0] md_rem_s;

  assign op_s        = aluop_e'(aluop);
  assign shamt_s     = b[SHW-1:0];
  assign b_zero_s    = (b == {XLEN{1'b0}});
  assign accept_s    = in_valid & (state_r == ST_IDLE);
  assign mul_start_s = accept_s & (op_s == OP_MUL);
  assign div_start_s = accept_s & is_multicycle(op_s) & (op_s != OP_MUL) & ~b_zero_s;

  // Single-cycle results; also supplies the divide-by-zero answers
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (op_s)
      OP_AND:  alu_s = a & b;
      OP_OR:   alu_s = a | b;
      OP_ADD:  alu_s = a + b;
      OP_SUB:  alu_s = a - b;
      OP_NOR:  alu_s = ~(a | b);
      OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_s = a << shamt_s;
      OP_SRL:  alu_s = a >> shamt_s;
      OP_SRA:  alu_s = $signed(a) >>> shamt_s;
      OP_DIVU: alu_s = {XLEN{1'b1}};
      OP_REMU: alu_s = a;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (mul_start_s | div_start_s),
    .div   (div_start_s),
    .a     (a),
    .b     (b),
    .done  (md_done_s),
    .prod  (md_prod_s),
    .quot  (md_quot_s),
    .rem   (md_rem_s)
  );

  // Pick the iterative result that matches the op in flight
  always_comb begin
    if (state_r == ST_DIV) begin
      md_res_s = rem_sel_r ? md_rem_s : md_quot_s;
    end else begin
      md_res_s = md_prod_s;
    end
  end

  // Controller next state and handshake outputs
  always_comb begin
    state_nx_s = state_r;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (mul_start_s) begin
          state_nx_s = ST_MUL;
        end else if (div_start_s) begin
          state_nx_s = ST_DIV;
        end else if (accept_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (md_done_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register and captured remainder/quotient select
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      rem_sel_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        rem_sel_r <= (op_s == OP_REMU);
      end else begin
        rem_sel_r <= rem_sel_r;
      end
    end
  end

  // Result register: loaded at accept for direct ops, on the last step otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= {XLEN{1'b0}};
      zero_r   <= 1'b1;
    end else if (accept_s && (state_nx_s == ST_DONE)) begin
      result_r <= alu_s;
      zero_r   <= (alu_s == {XLEN{1'b0}});
    end else if (md_done_s && ((state_r == ST_MUL) || (state_r == ST_DIV))) begin
      result_r <= md_res_s;
      zero_r   <= (md_res_s == {XLEN{1'b0}});
    end else begin
      result_r <= result_r;
      zero_r   <= zero_r;
    end
  end

  assign result = result_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (XLEN=64): directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_alu_seq;

  localparam int XLEN = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  aluop;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op definitions
  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b1100: r = ~(x | y);
      4'b0111: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'b1000: r = x << y[5:0];
      4'b1001: r = x >> y[5:0];
      4'b1010: r = $signed(x) >>> y[5:0];
      4'b0011: r = x * y;
      4'b0100: r = (y == 64'd0) ? {64{1'b1}} : x / y;
      4'b0101: r = (y == 64'd0) ? x : x % y;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] y);
    if (op == 4'b0011) return XLEN + 1;
    if ((op == 4'b0100 || op == 4'b0101) && y != 64'd0) return XLEN + 1;
    return 1;
  endfunction

  // Transaction model: one op in flight, result after its latency, held until taken
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cd = 0;
  logic [63:0] m_result = 64'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cd = 0; m_result = 64'd0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_busy) begin
      m_cd--;
      if (m_cd == 0) begin m_busy = 1'b0; m_valid = 1'b1; end
    end else if (in_valid) begin
      m_result = ref_alu(aluop, a, b);
      m_cd = ref_lat(aluop, b) - 1;
      if (m_cd == 0) m_valid = 1'b1;
      else m_busy = 1'b1;
    end
  end

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, !m_busy && !m_valid});
      chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      if (m_valid) begin
        chk("cyc_result", result, m_result);
        chk("cyc_zero", {63'd0, zero}, {63'd0, m_result == 64'd0});
      end
    end
  end

  // Issue one op, scramble the pins after accept, wait for the result and check it
  task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp, input int lat);
    int n;
    int rdy_seen;
    bit got;
    aluop = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; aluop = 4'($urandom);
    n = 0; got = 1'b0; rdy_seen = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1'b1;
      else if (in_ready) rdy_seen++;
    end
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_busy_ready"}, 64'(rdy_seen), 64'd0);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_zero"}, {63'd0, zero}, {63'd0, exp == 64'd0});
    @(posedge clk); #1;
  endtask

  int stale;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluop = 4'd0; a = 64'd0; b = 64'd0;
    repeat (2) @(posedge clk);
    #1; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("add", 4'b0010, 64'd5, 64'd7, 64'd12, 1);
    run_op("sub", 4'b0110, 64'd9, 64'd9, 64'd0, 1);
    run_op("slt", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    run_op("sra", 4'b1010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1);
    run_op("and", 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    run_op("nor", 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("sll", 4'b1000, 64'd1, 64'h44, 64'h10, 1);
    run_op("srl", 4'b1001, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
    run_op("undef", 4'b1111, 64'd123, 64'd456, 64'd0, 1);
    run_op("mul", 4'b0011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 65);
    run_op("mul_wrap", 4'b0011, 64'h8000_0000_0000_0001, 64'd2, 64'd2, 65);
    run_op("divu", 4'b0100, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu", 4'b0101, 64'd100, 64'd7, 64'd2, 65);
    run_op("divu_big", 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu0", 4'b0100, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0", 4'b0101, 64'd100, 64'd0, 64'd100, 1);

    // Consumer stall with a pending producer request
    out_ready = 1'b0;
    run_op("add_stall", 4'b0010, 64'd20, 64'd22, 64'd42, 1);
    aluop = 4'b0001; a = 64'hF0; b = 64'h0F; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_result", result, 64'd42);
      chk("stall_zero", {63'd0, zero}, 64'd0);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_release_valid", {63'd0, out_valid}, 64'd1);
    chk("after_release_result", result, 64'hFF);
    @(posedge clk); #1;

    // Reset during iteration 10 of a multiply
    aluop = 4'b0011; a = 64'd12345; b = 64'd678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_result", result, 64'd0);
    chk("midrst_zero", {63'd0, zero}, 64'd1);
    @(posedge clk); #1;
    run_op("add_after_rst", 4'b0010, 64'd3, 64'd4, 64'd7, 1);
    stale = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_mul", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
